// File: rtl/keyboard_decoder.sv
// keyboard_decoder
//   PS/2 keyboard receiver plus game-command decoder.
//   Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop),
//   tracks E0 (extended) and F0 (break) prefixes and turns the arrow keys /
//   WASD into a held 3-bit command.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   ps2_clk         in   keyboard clock (asynchronous to clk)
//   ps2_data        in   keyboard data  (asynchronous to clk)
//   keyboard_signal out  held command: 000 idle, 100 down, 101 left,
//                        110 right, 111 rotate
//   scan_code       out  last correctly received byte
//   code_strobe     out  one-cycle pulse per correctly received byte
//   frame_error     out  one-cycle pulse per rejected or timed-out frame
module keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] keyboard_signal,
    output logic [7:0] scan_code,
    output logic       code_strobe,
    output logic       frame_error
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ACT_NONE   = 3'b000;
    localparam logic [2:0] ACT_DOWN   = 3'b100;
    localparam logic [2:0] ACT_LEFT   = 3'b101;
    localparam logic [2:0] ACT_RIGHT  = 3'b110;
    localparam logic [2:0] ACT_ROTATE = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    // Synchronizers and edge detector
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             data_meta_q, data_sync_q;

    // Receiver
    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Decoder
    logic             e0_q, e0_d;
    logic             f0_q, f0_d;
    logic [2:0]       key_q, key_d;
    logic [7:0]       scan_q, scan_d;
    logic             strobe_q, strobe_d;
    logic             ferr_q, ferr_d;

    logic             ps2_fall;
    logic             frame_ok;
    logic             frame_bad;
    logic [2:0]       action;

    // Map a scan code to a command; ext selects the E0-prefixed table.
    function automatic logic [2:0] map_key(input logic [7:0] code, input logic ext);
        logic [2:0] act;
        act = ACT_NONE;
        if (ext) begin
            case (code)
                8'h72:   act = ACT_DOWN;
                8'h6B:   act = ACT_LEFT;
                8'h74:   act = ACT_RIGHT;
                8'h75:   act = ACT_ROTATE;
                default: act = ACT_NONE;
            endcase
        end else begin
            case (code)
                8'h1B:   act = ACT_DOWN;
                8'h1C:   act = ACT_LEFT;
                8'h23:   act = ACT_RIGHT;
                8'h1D:   act = ACT_ROTATE;
                default: act = ACT_NONE;
            endcase
        end
        return act;
    endfunction

    // Registered falling edge: previous synchronized level high, current low.
    assign ps2_fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_cnt_d = tmo_cnt_q;
        e0_d      = e0_q;
        f0_d      = f0_q;
        key_d     = key_q;
        scan_d    = scan_q;
        strobe_d  = 1'b0;
        ferr_d    = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        action    = ACT_NONE;

        case (state_q)
            S_IDLE: begin
                tmo_cnt_d = '0;
                bit_cnt_d = 4'd0;
                // A high sample here is line noise or a glitch, not a start bit.
                if (ps2_fall && !data_sync_q) begin
                    state_d   = S_RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            S_RECV: begin
                if (ps2_fall) begin
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        // Stop bit: shift_q holds {parity, data[7:0]}.
                        state_d   = S_IDLE;
                        bit_cnt_d = 4'd0;
                        if ((^shift_q) && data_sync_q) begin
                            frame_ok = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end else begin
                        // Shift in from the top so data bit 0 ends up at [0].
                        shift_d   = {data_sync_q, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_IDLE;
                    bit_cnt_d = 4'd0;
                    tmo_cnt_d = '0;
                    frame_bad = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = 4'd0;
                tmo_cnt_d = '0;
            end
        endcase

        if (frame_ok) begin
            strobe_d = 1'b1;
            scan_d   = shift_q[7:0];
            if (shift_q[7:0] == 8'hE0) begin
                e0_d = 1'b1;
            end else if (shift_q[7:0] == 8'hF0) begin
                f0_d = 1'b1;
            end else begin
                action = map_key(shift_q[7:0], e0_q);
                e0_d   = 1'b0;
                f0_d   = 1'b0;
                if (action != ACT_NONE) begin
                    if (!f0_q) begin
                        // Make: newest press wins; a typematic repeat rewrites the same value.
                        key_d = action;
                    end else if (action == key_q) begin
                        // Break only releases the command it belongs to.
                        key_d = ACT_NONE;
                    end
                end
            end
        end

        if (frame_bad) begin
            ferr_d = 1'b1;
            e0_d   = 1'b0;
            f0_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 9'd0;
            tmo_cnt_q   <= '0;
            e0_q        <= 1'b0;
            f0_q        <= 1'b0;
            key_q       <= ACT_NONE;
            scan_q      <= 8'h00;
            strobe_q    <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_cnt_q   <= tmo_cnt_d;
            e0_q        <= e0_d;
            f0_q        <= f0_d;
            key_q       <= key_d;
            scan_q      <= scan_d;
            strobe_q    <= strobe_d;
            ferr_q      <= ferr_d;
        end
    end

    assign keyboard_signal = key_q;
    assign scan_code       = scan_q;
    assign code_strobe     = strobe_q;
    assign frame_error     = ferr_q;

endmodule

// File: tb/tb_keyboard_decoder.sv
// tb_keyboard_decoder
//   Directed bench for keyboard_decoder: drives PS/2 frames bit by bit and
//   checks the decoded command, scan code and strobe/error pulses.
module tb_keyboard_decoder;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] keyboard_signal;
    logic [7:0] scan_code;
    logic       code_strobe;
    logic       frame_error;

    int checks   = 0;
    int failures = 0;

    int cyc          = 0;
    int fall_cyc     = 0;
    int strobe_total = 0;
    int err_total    = 0;
    int cap_lat      = 0;
    logic [7:0] cap_scan = 8'h00;
    logic [2:0] cap_ks   = 3'b000;

    int s0, e0;

    keyboard_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst             (rst),
        .ps2_clk         (ps2_clk),
        .ps2_data        (ps2_data),
        .keyboard_signal (keyboard_signal),
        .scan_code       (scan_code),
        .code_strobe     (code_strobe),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (code_strobe) begin
            strobe_total <= strobe_total + 1;
            cap_scan     <= scan_code;
            cap_ks       <= keyboard_signal;
            cap_lat      <= cyc - fall_cyc;
        end
        if (frame_error) err_total <= err_total + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] build(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            repeat (10) @(negedge clk);
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            repeat (10) @(negedge clk);
            ps2_clk  = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bits(build(b, flip), 11);
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ks",     keyboard_signal, 0);
        check("reset_scan",   scan_code, 0);
        check("reset_strobe", code_strobe, 0);
        check("reset_ferr",   frame_error, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain make of A -> left
        s0 = strobe_total; e0 = err_total;
        send_frame(8'h1C, 1'b0);
        check("1c_strobes",  strobe_total - s0, 1);
        check("1c_cap_scan", cap_scan, 8'h1C);
        check("1c_cap_ks",   cap_ks, 3'b101);
        check("1c_latency",  cap_lat, 3);
        check("1c_no_err",   err_total - e0, 0);
        check("1c_strobe_low", code_strobe, 0);

        // Extended rotate make then break
        s0 = strobe_total;
        send_frame(8'hE0, 1'b0);
        check("e0_no_change", keyboard_signal, 3'b101);
        send_frame(8'h75, 1'b0);
        check("e0_75_make", keyboard_signal, 3'b111);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        check("f0_no_change", keyboard_signal, 3'b111);
        send_frame(8'h75, 1'b0);
        check("e0_75_break", keyboard_signal, 3'b000);
        check("seq_strobes", strobe_total - s0, 5);
        check("seq_scan",    scan_code, 8'h75);

        // Newest press wins; break of a non-held key is ignored
        send_frame(8'h1B, 1'b0);
        check("1b_make", keyboard_signal, 3'b100);
        send_frame(8'h23, 1'b0);
        check("23_make", keyboard_signal, 3'b110);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);
        check("1b_break_kept", keyboard_signal, 3'b110);
        check("1b_break_scan", scan_code, 8'h1B);

        // Bad parity
        s0 = strobe_total; e0 = err_total;
        send_frame(8'h1C, 1'b1);
        check("par_err",     err_total - e0, 1);
        check("par_strobes", strobe_total - s0, 0);
        check("par_scan",    scan_code, 8'h1B);
        check("par_ks",      keyboard_signal, 3'b110);
        send_frame(8'h1D, 1'b0);
        check("1d_after_err", keyboard_signal, 3'b111);

        // Timeout after 5 bits; pending E0 must be discarded
        send_frame(8'hE0, 1'b0);
        e0 = err_total;
        send_bits(build(8'h72, 1'b0), 5);
        repeat (TMO + 100) @(negedge clk);
        check("tmo_err", err_total - e0, 1);
        check("tmo_ks",  keyboard_signal, 3'b111);
        send_frame(8'h72, 1'b0);
        check("72_no_e0", keyboard_signal, 3'b111);
        check("72_scan",  scan_code, 8'h72);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h72, 1'b0);
        check("e0_72_down", keyboard_signal, 3'b100);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h72, 1'b0);
        check("typematic", keyboard_signal, 3'b100);
        check("tmo_only_once", err_total - e0, 1);

        // Reset mid-frame
        send_frame(8'h23, 1'b0);
        check("pre_rst_ks", keyboard_signal, 3'b110);
        e0 = err_total;
        send_bits(build(8'h1C, 1'b0), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_ks",     keyboard_signal, 0);
        check("rst_scan",   scan_code, 0);
        check("rst_strobe", code_strobe, 0);
        check("rst_ferr",   frame_error, 0);
        repeat (TMO + 100) @(negedge clk);
        check("rst_no_err", err_total - e0, 0);
        send_frame(8'h1D, 1'b0);
        check("post_rst_ks",   keyboard_signal, 3'b111);
        check("post_rst_scan", scan_code, 8'h1D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
